// File: rtl/servo_pkg.sv
// Shared types and constants for the four-channel servo PWM driver.
// Latency: n/a (types, constants and a combinational clamp helper only).
// Backpressure: n/a.
package servo_pkg;

    localparam int unsigned NUM_SERVOS   = 4;
    localparam int unsigned ANGLE_W      = 8;
    localparam int unsigned ANGLE_MAX    = 180;
    localparam int unsigned ANGLE_CENTER = 90;
    localparam int unsigned PULSE_W      = 22;

    typedef logic [ANGLE_W-1:0] angle_t;
    typedef logic [PULSE_W-1:0] pulse_t;

    // Targets beyond the mechanical range are pinned to full travel.
    function automatic angle_t clamp_angle(input angle_t a);
        return (a > angle_t'(ANGLE_MAX)) ? angle_t'(ANGLE_MAX) : a;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: latched target, slew-limited current angle, pulse width and PWM compare.
// Latency: target visible to the stepper 1 cycle after load; new width applies from the next frame; PWM is 1 cycle behind frame_cnt.
// Backpressure: none; a target load is always accepted. SERVO_SLEW_EN selects slew-limited stepping, otherwise each frame jumps to target.
module servo_channel
    import servo_pkg::*;
#(
    parameter int unsigned MIN_TICKS     = 50_000,
    parameter int unsigned TICKS_PER_DEG = 1_111,
    parameter int unsigned SLEW_DEG      = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         target_valid_i,
    input  logic [7:0]   target_angle_i,
    input  logic         step_i,
    input  logic         enable_i,
    input  logic [21:0]  frame_cnt_i,
    output logic         pwm_o,
    output logic [7:0]   cur_angle_o,
    output logic         settled_o
);

`ifdef SERVO_SLEW_EN
    localparam int unsigned STEP_LIM = SLEW_DEG;
`else
    // A limit covering the full sweep means every step lands on the target.
    localparam int unsigned STEP_LIM = (SLEW_DEG > ANGLE_MAX) ? SLEW_DEG : ANGLE_MAX;
`endif
    // Any limit of a full sweep or more behaves identically, so cap it to fit 9 bits.
    localparam logic [8:0]  STEP_W      = (STEP_LIM > ANGLE_MAX) ? 9'(ANGLE_MAX) : 9'(STEP_LIM);
    localparam pulse_t      MIN_P       = pulse_t'(MIN_TICKS);
    localparam logic [17:0] TPD_W       = 18'(TICKS_PER_DEG);
    localparam pulse_t      RESET_PULSE = MIN_P + pulse_t'(18'(ANGLE_CENTER) * TPD_W);

    angle_t      tgt_q, tgt_d;
    angle_t      cur_q, cur_d;
    pulse_t      pulse_q, pulse_d;
    logic        pwm_q, pwm_d;

    logic [8:0]  cur_w, tgt_w, diff, stepped;
    logic [17:0] prod;

    assign cur_w = {1'b0, cur_q};
    assign tgt_w = {1'b0, tgt_q};
    assign prod  = {9'd0, stepped} * TPD_W;

    // Move toward the target by at most the step limit, landing exactly on it when close.
    always_comb begin
        diff    = '0;
        stepped = cur_w;
        if (tgt_w >= cur_w) begin
            diff    = tgt_w - cur_w;
            stepped = (diff <= STEP_W) ? tgt_w : (cur_w + STEP_W);
        end else begin
            diff    = cur_w - tgt_w;
            stepped = (diff <= STEP_W) ? tgt_w : (cur_w - STEP_W);
        end
    end

    // Next-state: target latch, frame-boundary step with new width, PWM compare against the current width.
    always_comb begin
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        pulse_d = pulse_q;
        pwm_d   = enable_i && (frame_cnt_i < pulse_q);
        if (target_valid_i) begin
            tgt_d = clamp_angle(target_angle_i);
        end
        if (step_i) begin
            cur_d   = angle_t'(stepped);
            pulse_d = MIN_P + pulse_t'(prod);
        end
    end

    // Channel state registers; reset parks the joint at centre with the output low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q   <= angle_t'(ANGLE_CENTER);
            cur_q   <= angle_t'(ANGLE_CENTER);
            pulse_q <= RESET_PULSE;
            pwm_q   <= 1'b0;
        end else begin
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            pulse_q <= pulse_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o       = pwm_q;
    assign cur_angle_o = cur_q;
    assign settled_o   = (cur_q == tgt_q);

endmodule

// File: rtl/servo_pwm_driver.sv
// Four-channel hobby-servo PWM driver with a shared frame counter (SERVO_SLEW_EN enables per-frame slew limiting).
// Latency: PWM 1 cycle behind the frame counter; frame_start and all_settled registered (1 cycle).
// Backpressure: none; targets are sampled whenever target_valid is high.
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_TICKS   = 2_000_000,
    parameter int unsigned MIN_TICKS     = 50_000,
    parameter int unsigned TICKS_PER_DEG = 1_111,
    parameter int unsigned SLEW_DEG      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        target_valid,
    input  logic [7:0]  target0_angle,
    input  logic [7:0]  target1_angle,
    input  logic [7:0]  target2_angle,
    input  logic [7:0]  target3_angle,
    input  logic        enable,
    output logic [3:0]  pwm_out,
    output logic [31:0] cur_angles,
    output logic        frame_start,
    output logic        all_settled
);

    localparam pulse_t FRAME_LAST = pulse_t'(FRAME_TICKS - 1);

    pulse_t frame_cnt_q, frame_cnt_d;
    logic   frame_start_q, frame_start_d;
    logic   all_settled_q, all_settled_d;
    logic   step;

    logic [NUM_SERVOS-1:0]              settled;
    logic [NUM_SERVOS-1:0][ANGLE_W-1:0] tgt_in;
    logic [NUM_SERVOS-1:0][ANGLE_W-1:0] cur_arr;

    assign tgt_in = {target3_angle, target2_angle, target1_angle, target0_angle};
    assign step   = (frame_cnt_q == FRAME_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SERVOS; gi++) begin : g_ch
            servo_channel #(
                .MIN_TICKS     (MIN_TICKS),
                .TICKS_PER_DEG (TICKS_PER_DEG),
                .SLEW_DEG      (SLEW_DEG)
            ) u_ch (
                .clk            (clk),
                .rst            (rst),
                .target_valid_i (target_valid),
                .target_angle_i (tgt_in[gi]),
                .step_i         (step),
                .enable_i       (enable),
                .frame_cnt_i    (frame_cnt_q),
                .pwm_o          (pwm_out[gi]),
                .cur_angle_o    (cur_arr[gi]),
                .settled_o      (settled[gi])
            );
        end
    endgenerate

    // Free-running frame counter (ignores enable), start-of-frame pulse and settled reduction.
    always_comb begin
        frame_cnt_d   = step ? '0 : (frame_cnt_q + 1'b1);
        frame_start_d = (frame_cnt_q == '0);
        all_settled_d = &settled;
    end

    // Shared frame timing registers; counter restarts at 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            all_settled_q <= 1'b1;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            all_settled_q <= all_settled_d;
        end
    end

    assign cur_angles  = cur_arr;
    assign frame_start = frame_start_q;
    assign all_settled = all_settled_q;

endmodule
